// File: rtl/wt_cache_pkg.sv
// Shared write-through cache geometry, replacement-update record and arbiter FSM states.
package wt_cache_pkg;

  localparam int DCACHE_CL_IDX_WIDTH = 8;
  localparam int DCACHE_SET_ASSOC    = 4;
  localparam int DCACHE_WAY_WIDTH    = $clog2(DCACHE_SET_ASSOC);

  typedef struct packed {
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_WAY_WIDTH-1:0]    way;
  } repl_upd_t;

  typedef enum logic {
    REPL_RUN  = 1'b0,
    REPL_WALK = 1'b1
  } repl_state_e;

endpackage

// File: rtl/wt_dcache_repl_fifo.sv
// Small circular buffer holding accepted hit updates until the replacement port is free.
module wt_dcache_repl_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count and pointers decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wt_dcache_repl_arb.sv
// Replacement-state update arbiter: refill updates bypass, hit updates are round-robin
// granted into a buffer, and flush/reset walk every set to reinitialise its state.
module wt_dcache_repl_arb
  import wt_cache_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = DCACHE_CL_IDX_WIDTH,
  parameter int WAY_W      = $clog2(DCACHE_SET_ASSOC)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  output logic                       flush_ack_o,
  input  logic [NUM_PORTS-1:0]       hit_req_i,
  input  logic [NUM_PORTS*IDX_W-1:0] hit_idx_i,
  input  logic [NUM_PORTS*WAY_W-1:0] hit_way_i,
  output logic [NUM_PORTS-1:0]       hit_gnt_o,
  input  logic                       miss_upd_i,
  input  logic [IDX_W-1:0]           miss_idx_i,
  input  logic [WAY_W-1:0]           miss_way_i,
  output logic                       upd_valid_o,
  output logic [IDX_W-1:0]           upd_idx_o,
  output logic [WAY_W-1:0]           upd_way_o,
  output logic                       upd_miss_o,
  output logic                       init_o,
  output logic [IDX_W-1:0]           init_idx_o,
  output logic                       busy_o
);

  localparam int ENTRY_W = IDX_W + WAY_W;
  localparam int RR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  repl_state_e        state_q;
  logic [IDX_W-1:0]   walk_cnt_q;
  logic [RR_W-1:0]    rr_q, rr_d;

  logic               run, walk, walk_last;
  logic               gnt_found, grant_ok;
  logic [RR_W-1:0]    gnt_port;
  logic [ENTRY_W-1:0] push_data, fifo_head;
  logic               fifo_full, fifo_empty, fifo_pop, fifo_flush;
  logic [CNT_W-1:0]   fifo_count;
  logic [IDX_W-1:0]   head_idx;
  logic [WAY_W-1:0]   head_way;
  logic               head_drop;

  // Reset forces every request-facing output low in the cycle it is applied.
  assign run       = (state_q == REPL_RUN)  && !rst_i;
  assign walk      = (state_q == REPL_WALK) && !rst_i;
  assign walk_last = (walk_cnt_q == {IDX_W{1'b1}});

  always_comb begin
    gnt_found = 1'b0;
    gnt_port  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_found && hit_req_i[(int'(rr_q) + k) % NUM_PORTS]) begin
        gnt_found = 1'b1;
        gnt_port  = RR_W'((int'(rr_q) + k) % NUM_PORTS);
      end
    end
  end

  // A full buffer refuses grants even when its head leaves this cycle.
  assign grant_ok  = run && !flush_i && !fifo_full && gnt_found;
  assign rr_d      = (int'(gnt_port) == NUM_PORTS - 1) ? '0 : gnt_port + 1'b1;
  assign push_data = {hit_idx_i[int'(gnt_port)*IDX_W +: IDX_W],
                      hit_way_i[int'(gnt_port)*WAY_W +: WAY_W]};

  always_comb begin
    hit_gnt_o = '0;
    if (grant_ok) hit_gnt_o[gnt_port] = 1'b1;
  end

  assign head_idx   = fifo_head[ENTRY_W-1 -: IDX_W];
  assign head_way   = fifo_head[WAY_W-1:0];
  // A refill of the same set supersedes the buffered hit, so the hit is dropped.
  assign head_drop  = miss_upd_i && (head_idx == miss_idx_i);
  assign fifo_pop   = run && !fifo_empty && (!miss_upd_i || head_drop);
  assign fifo_flush = run && flush_i;

  assign upd_valid_o = run && (miss_upd_i || !fifo_empty);
  assign upd_miss_o  = run && miss_upd_i;
  assign upd_idx_o   = miss_upd_i ? miss_idx_i : head_idx;
  assign upd_way_o   = miss_upd_i ? miss_way_i : head_way;

  assign init_o      = walk;
  assign init_idx_o  = walk_cnt_q;
  assign flush_ack_o = walk && walk_last;
  assign busy_o      = (state_q == REPL_WALK) || (fifo_count != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= REPL_WALK;
      walk_cnt_q <= '0;
      rr_q       <= '0;
    end else begin
      case (state_q)
        REPL_RUN: begin
          if (grant_ok) rr_q <= rr_d;
          if (flush_i) begin
            state_q    <= REPL_WALK;
            walk_cnt_q <= '0;
          end
        end
        REPL_WALK: begin
          walk_cnt_q <= walk_cnt_q + 1'b1;
          if (walk_last) state_q <= REPL_RUN;
        end
        default: state_q <= REPL_WALK;
      endcase
    end
  end

  wt_dcache_repl_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (grant_ok),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_wt_dcache_repl_arb.sv
// Self-checking bench for wt_dcache_repl_arb: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_wt_dcache_repl_arb;
  import wt_cache_pkg::*;

  localparam int NP = 3;
  localparam int DEPTH = 4;
  localparam int IW = 8;
  localparam int WW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i, flush_i, miss_upd_i;
  logic [NP-1:0]      hit_req_i;
  logic [NP*IW-1:0]   hit_idx_i;
  logic [NP*WW-1:0]   hit_way_i;
  logic [IW-1:0]      miss_idx_i;
  logic [WW-1:0]      miss_way_i;
  logic               flush_ack_o, upd_valid_o, upd_miss_o, init_o, busy_o;
  logic [NP-1:0]      hit_gnt_o;
  logic [IW-1:0]      upd_idx_o, init_idx_o;
  logic [WW-1:0]      upd_way_o;

  int total = 0;
  int bad   = 0;

  wt_dcache_repl_arb #(
    .NUM_PORTS (NP), .FIFO_DEPTH (DEPTH), .IDX_W (IW), .WAY_W (WW)
  ) dut (
    .clk_i (clk), .rst_i (rst_i), .flush_i (flush_i), .flush_ack_o (flush_ack_o),
    .hit_req_i (hit_req_i), .hit_idx_i (hit_idx_i), .hit_way_i (hit_way_i),
    .hit_gnt_o (hit_gnt_o), .miss_upd_i (miss_upd_i), .miss_idx_i (miss_idx_i),
    .miss_way_i (miss_way_i), .upd_valid_o (upd_valid_o), .upd_idx_o (upd_idx_o),
    .upd_way_o (upd_way_o), .upd_miss_o (upd_miss_o), .init_o (init_o),
    .init_idx_o (init_idx_o), .busy_o (busy_o)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush_i = 1'b0; miss_upd_i = 1'b0; hit_req_i = '0;
    hit_idx_i = '0; hit_way_i = '0; miss_idx_i = '0; miss_way_i = '0;
  endtask

  task automatic set_port(input int p, input int idx, input int way);
    hit_idx_i[p*IW +: IW] = IW'(idx);
    hit_way_i[p*WW +: WW] = WW'(way);
  endtask

  task automatic test_reset();
    clr();
    rst_i = 1'b1; flush_i = 1'b1; hit_req_i = '1; miss_upd_i = 1'b1; miss_idx_i = 8'd3;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      total++;
      if ({hit_gnt_o, upd_valid_o, flush_ack_o, init_o} !== 6'b0) begin
        bad++;
        $display("FAIL reset_hold cyc %0d got gnt=%b valid=%b ack=%b init=%b want all 0",
                 c, hit_gnt_o, upd_valid_o, flush_ack_o, init_o);
      end
    end
    rst_i = 1'b0;
    clr();
  endtask

  // Full walk from the current cycle (counter 0); requests, refills and flushes must be ignored.
  task automatic test_walk();
    for (int i = 0; i < 256; i++) begin
      hit_req_i = '1; miss_upd_i = 1'b1;
      miss_idx_i = IW'($urandom); flush_i = 1'($urandom);
      #1;
      total++;
      if ({init_o, init_idx_o, flush_ack_o, busy_o} !== {1'b1, IW'(i), (i == 255), 1'b1}) begin
        bad++;
        $display("FAIL walk_step i=%0d got init=%b idx=%0d ack=%b busy=%b want init=1 idx=%0d ack=%b busy=1",
                 i, init_o, init_idx_o, flush_ack_o, busy_o, i, (i == 255));
      end
      total++;
      if ({hit_gnt_o, upd_valid_o} !== 4'b0) begin
        bad++;
        $display("FAIL walk_quiet i=%0d got gnt=%b valid=%b want 0", i, hit_gnt_o, upd_valid_o);
      end
      next_cycle();
    end
    clr();
    #1;
    total++;
    if ({init_o, flush_ack_o, busy_o, upd_valid_o} !== 4'b0) begin
      bad++;
      $display("FAIL walk_end got init=%b ack=%b busy=%b valid=%b want 0",
               init_o, flush_ack_o, busy_o, upd_valid_o);
    end
  endtask

  task automatic test_rr_grant();
    logic [NP-1:0] fill_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
    logic [NP-1:0] drn_g  [6] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    int            drn_i  [5] = '{10, 11, 12, 10, 11};
    int            drn_w  [5] = '{1, 2, 3, 1, 2};
    clr();
    for (int p = 0; p < NP; p++) set_port(p, 10 + p, p + 1);
    hit_req_i = '1; miss_upd_i = 1'b1; miss_idx_i = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (hit_gnt_o !== fill_g[c]) begin
        bad++;
        $display("FAIL rr_fill_gnt c=%0d got %b want %b", c, hit_gnt_o, fill_g[c]);
      end
      total++;
      if ({upd_valid_o, upd_miss_o, upd_idx_o} !== {2'b11, 8'hFF}) begin
        bad++;
        $display("FAIL rr_fill_miss c=%0d got valid=%b miss=%b idx=%0d want 1 1 255",
                 c, upd_valid_o, upd_miss_o, upd_idx_o);
      end
      next_cycle();
    end
    miss_upd_i = 1'b0;
    for (int r = 0; r < 6; r++) begin
      hit_req_i = (r < 2) ? '1 : '0;
      #1;
      total++;
      if (hit_gnt_o !== drn_g[r]) begin
        bad++;
        $display("FAIL rr_drain_gnt r=%0d got %b want %b", r, hit_gnt_o, drn_g[r]);
      end
      total++;
      if (r < 5) begin
        if ({upd_valid_o, upd_miss_o, upd_idx_o, upd_way_o} !== {2'b10, IW'(drn_i[r]), WW'(drn_w[r])}) begin
          bad++;
          $display("FAIL rr_drain_upd r=%0d got v=%b m=%b idx=%0d way=%0d want v=1 m=0 idx=%0d way=%0d",
                   r, upd_valid_o, upd_miss_o, upd_idx_o, upd_way_o, drn_i[r], drn_w[r]);
        end
      end else if ({upd_valid_o, busy_o} !== 2'b00) begin
        bad++;
        $display("FAIL rr_drain_empty got valid=%b busy=%b want 0 0", upd_valid_o, busy_o);
      end
      next_cycle();
    end
  endtask

  task automatic test_miss_collision();
    clr();
    hit_req_i = 3'b001; set_port(0, 5, 2); miss_upd_i = 1'b1; miss_idx_i = 8'hFF;
    #1;
    total++;
    if (hit_gnt_o !== 3'b001) begin bad++; $display("FAIL mc_gnt_a got %b want 001", hit_gnt_o); end
    next_cycle();
    set_port(0, 7, 3);
    #1;
    total++;
    if (hit_gnt_o !== 3'b001) begin bad++; $display("FAIL mc_gnt_b got %b want 001", hit_gnt_o); end
    next_cycle();
    hit_req_i = '0; miss_idx_i = 8'd5; miss_way_i = 2'd1;
    #1;
    total++;
    if ({upd_valid_o, upd_idx_o, upd_way_o, upd_miss_o} !== {1'b1, 8'd5, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL mc_same_idx got v=%b idx=%0d way=%0d m=%b want 1 5 1 1",
               upd_valid_o, upd_idx_o, upd_way_o, upd_miss_o);
    end
    next_cycle();
    miss_idx_i = 8'd9; miss_way_i = 2'd0;
    #1;
    total++;
    if ({upd_valid_o, upd_idx_o, upd_way_o, upd_miss_o} !== {1'b1, 8'd9, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL mc_other_idx got v=%b idx=%0d way=%0d m=%b want 1 9 0 1",
               upd_valid_o, upd_idx_o, upd_way_o, upd_miss_o);
    end
    next_cycle();
    miss_upd_i = 1'b0;
    #1;
    total++;
    if ({upd_valid_o, upd_idx_o, upd_way_o, upd_miss_o} !== {1'b1, 8'd7, 2'd3, 1'b0}) begin
      bad++;
      $display("FAIL mc_held_head got v=%b idx=%0d way=%0d m=%b want 1 7 3 0",
               upd_valid_o, upd_idx_o, upd_way_o, upd_miss_o);
    end
    next_cycle();
    #1;
    total++;
    if ({upd_valid_o, busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL mc_empty got valid=%b busy=%b want 0 0", upd_valid_o, busy_o);
    end
  endtask

  task automatic test_flush();
    clr();
    hit_req_i = 3'b001; miss_upd_i = 1'b1; miss_idx_i = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      set_port(0, 20 + c, c);
      #1;
      total++;
      if (hit_gnt_o !== 3'b001) begin bad++; $display("FAIL fl_fill c=%0d got %b want 001", c, hit_gnt_o); end
      next_cycle();
    end
    hit_req_i = '0; flush_i = 1'b1;
    #1;
    total++;
    if ({busy_o, init_o} !== 2'b10) begin
      bad++;
      $display("FAIL fl_pulse got busy=%b init=%b want 1 0", busy_o, init_o);
    end
    next_cycle();
    test_walk();
  endtask

  task automatic test_reset_midwalk();
    clr();
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      #1;
      total++;
      if ({init_o, init_idx_o, flush_ack_o} !== {1'b1, IW'(i), 1'b0}) begin
        bad++;
        $display("FAIL mw_walk i=%0d got init=%b idx=%0d ack=%b want 1 %0d 0",
                 i, init_o, init_idx_o, flush_ack_o, i);
      end
      if (i < 100) next_cycle();
    end
    rst_i = 1'b1; hit_req_i = '1; miss_upd_i = 1'b1;
    #1;
    total++;
    if ({init_o, flush_ack_o, hit_gnt_o, upd_valid_o} !== 6'b0) begin
      bad++;
      $display("FAIL mw_rst got init=%b ack=%b gnt=%b valid=%b want 0",
               init_o, flush_ack_o, hit_gnt_o, upd_valid_o);
    end
    next_cycle();
    rst_i = 1'b0;
    clr();
    test_walk();
  endtask

  // Reference model: a queue of accepted updates, the round-robin pointer and a walk counter.
  task automatic test_random();
    logic        m_walk = 1'b0;
    int          m_wcnt = 0;
    int          m_rr   = 0;
    repl_upd_t   q[$];
    int          gp;
    repl_upd_t   e;
    logic [24:0] got, exp;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_i      = ($urandom_range(0, 299) == 0);
      flush_i    = ($urandom_range(0, 199) == 0);
      hit_req_i  = NP'($urandom);
      for (int p = 0; p < NP; p++) set_port(p, $urandom_range(0, 7), $urandom_range(0, 3));
      miss_upd_i = 1'($urandom);
      miss_idx_i = IW'($urandom_range(0, 7));
      miss_way_i = WW'($urandom);
      #1;
      gp = -1;
      exp = '0;
      if (!rst_i && m_walk) begin
        exp = {3'b000, 1'b0, 11'b0, 1'b1, IW'(m_wcnt), (m_wcnt == 255)};
      end else if (!rst_i) begin
        if (!flush_i && q.size() < DEPTH)
          for (int k = 0; k < NP; k++)
            if (gp < 0 && hit_req_i[(m_rr + k) % NP]) gp = (m_rr + k) % NP;
        exp[24:22] = (gp >= 0) ? NP'(1 << gp) : '0;
        if (miss_upd_i)        exp[21:10] = {1'b1, miss_idx_i, miss_way_i, 1'b1};
        else if (q.size() > 0) exp[21:10] = {1'b1, q[0].idx, q[0].way, 1'b0};
      end
      got = {hit_gnt_o, upd_valid_o, upd_valid_o ? {upd_idx_o, upd_way_o, upd_miss_o} : 11'b0,
             init_o, init_o ? init_idx_o : 8'b0, flush_ack_o};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rnd_out cyc=%0d got %h want %h (gnt|v|idx,way,m|init|iidx|ack)", cyc, got, exp);
      end
      if (!rst_i) begin
        total++;
        if (busy_o !== (m_walk || q.size() != 0)) begin
          bad++;
          $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, busy_o, (m_walk || q.size() != 0));
        end
      end
      next_cycle();
      if (rst_i) begin
        m_walk = 1'b1; m_wcnt = 0; m_rr = 0; q.delete();
      end else if (m_walk) begin
        if (m_wcnt == 255) m_walk = 1'b0;
        else m_wcnt++;
      end else begin
        if (q.size() > 0 && (!miss_upd_i || q[0].idx == miss_idx_i)) void'(q.pop_front());
        if (gp >= 0) begin
          e.idx = hit_idx_i[gp*IW +: IW];
          e.way = hit_way_i[gp*WW +: WW];
          q.push_back(e);
          m_rr = (gp + 1) % NP;
        end
        if (flush_i) begin
          m_walk = 1'b1; m_wcnt = 0; q.delete();
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_i = 1'b1;
    test_reset();
    test_walk();
    test_rr_grant();
    test_miss_collision();
    test_flush();
    test_reset_midwalk();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wt_dcache_repl_arb.md
WT_DCACHE_REPL_ARB -- requirements
Module: wt_dcache_repl_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, 3, number of hit-update requesters.
REQ-002 SHALL have parameter FIFO_DEPTH, 4, hit-update buffer entries (power of two, >=2).
REQ-003 SHALL have parameter IDX_W, DCACHE_CL_IDX_WIDTH, set-index width; WAY_W, $clog2(DCACHE_SET_ASSOC), way width.
REQ-004 SHALL have ports: clk_i  in  1  single clock; rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: flush_i  in  1  flush request pulse; flush_ack_o  out  1  one-cycle walk-complete pulse.
REQ-006 SHALL have ports: hit_req_i  in  NUM_PORTS  hit-update requests; hit_idx_i  in  NUM_PORTS x IDX_W; hit_way_i  in  NUM_PORTS x WAY_W; hit_gnt_o  out  NUM_PORTS  one-hot accept.
REQ-007 SHALL have ports: miss_upd_i  in  1  refill-update valid; miss_idx_i  in  IDX_W; miss_way_i  in  WAY_W.
REQ-008 SHALL have ports: upd_valid_o  out  1; upd_idx_o  out  IDX_W; upd_way_o  out  WAY_W; upd_miss_o  out  1  update is a refill.
REQ-009 SHALL have ports: init_o  out  1  reinitialise replacement state of init_idx_o; init_idx_o  out  IDX_W; busy_o  out  1  walk active or buffer non-empty.

Function
REQ-010 SHALL implement FSM states RUN and WALK; WALK drives init_o=1 with init_idx_o = counter, counter +1 per cycle.
REQ-011 SHALL leave WALK on the cycle init_idx_o = 2^IDX_W-1, pulsing flush_ack_o that same cycle, entering RUN next cycle.
REQ-012 SHALL on flush_i in RUN enter WALK next cycle with counter 0 and discard all buffered hit updates.
REQ-013 SHALL ignore flush_i during WALK (walk neither restarts nor extends).
REQ-014 SHALL in WALK hold hit_gnt_o=0, upd_valid_o=0 and drop miss_upd_i.
REQ-015 SHALL in RUN pass miss_upd_i combinationally to upd_* with upd_miss_o=1 (zero latency, absolute priority).
REQ-016 SHALL in RUN grant at most one hit_req_i per cycle, round-robin, starting search at pointer rr; rr becomes granted port+1 (mod NUM_PORTS) after a grant, unchanged otherwise.
REQ-017 SHALL grant only when buffer count < FIFO_DEPTH; a full buffer gives hit_gnt_o=0 even if popping that cycle.
REQ-018 SHALL push the granted {idx,way} into the buffer; earliest appearance on upd_* is the next cycle.
REQ-019 SHALL pop the buffer head onto upd_* (upd_miss_o=0) in cycles without miss_upd_i; with miss_upd_i the head is held.
REQ-020 SHALL discard the head (no output) when miss_upd_i is asserted and head idx equals miss_idx_i.
REQ-021 SHALL preserve acceptance order of hit updates; no update is duplicated or lost except per REQ-012/REQ-020.
REQ-022 SHALL drive busy_o = (state==WALK) or (count!=0).

Reset
REQ-023 SHALL on rst_i enter WALK with counter 0, buffer empty, rr=0; a reset-initiated walk also ends with flush_ack_o.
REQ-024 SHALL hold during reset cycle: hit_gnt_o=0, upd_valid_o=0, flush_ack_o=0, init_o=0, busy_o=1 from the first post-reset cycle until walk end.
REQ-025 SHALL on rst_i mid-walk or mid-buffer abandon all state and restart per REQ-023.

Structure
REQ-026 SHALL place typedef repl_upd_t {idx IDX_W, way WAY_W} in wt_cache_pkg; DCACHE_CL_IDX_WIDTH, DCACHE_SET_ASSOC sourced from wt_cache_pkg.
REQ-027 SHALL implement the buffer as sub-module wt_dcache_repl_fifo (push, pop, flush, full, empty, count, head); arbiter and FSM stay in top.

Verification
REQ-028 Reset, IDX_W=8 -> init_o 256 cycles, init_idx_o 0..255, flush_ack_o at idx 255, then busy_o=0.
REQ-029 All 3 ports request continuously in RUN, no miss -> grants 0,1,2,0,1,2; after 4 grants with no pops stalled by misses, gnt=0.
REQ-030 Head {idx 5, way 2}, miss_upd_i {idx 5, way 1} same cycle -> upd_* = {5,1,miss=1}, head discarded, next output is following entry.
REQ-031 Head {idx 7, way 3}, miss {idx 9, way 0} -> output miss this cycle, {7,3,miss=0} next cycle.
REQ-032 3 entries buffered, flush_i -> next cycle WALK, buffer empty, miss updates ignored, no hit output until after flush_ack_o.
REQ-033 rst_i asserted at init_idx_o=100 -> next walk restarts at 0, no flush_ack_o for aborted walk.
